// File: rtl/data_mem_access.sv
// Data-memory access stage: turns a load/store from EX/MEM into a held memory
// request, stalls the pipeline until the memory acks, and aligns load data.
module data_mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic        mem_ack,
  input  logic [31:0] mem_readdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  output logic        busywait,
  output logic [31:0] d_mem_result,
  output logic        misaligned,
  output logic [1:0]  dbg_state
);

  // Handshake: mem_read/mem_write (valid) stay asserted with address, data and
  // byteenable stable until the single-cycle mem_ack (ready); one ack per request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        is_read_q, is_read_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] result_q, result_d;

  logic        req;
  logic        legal;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] ld_shift;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign req = mem_read_in | mem_write_in;

  always_comb begin
    legal = 1'b0;
    case (funct3_in)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~alu_result_in[0];
      3'b010:         legal = (alu_result_in[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  // Store lanes: the narrow datum is replicated so any lane the enable selects is right.
  always_comb begin
    st_data = write_data_in;
    st_be   = 4'b1111;
    case (funct3_in[1:0])
      2'b00: begin
        st_data = {4{write_data_in[7:0]}};
        st_be   = 4'b0001 << alu_result_in[1:0];
      end
      2'b01: begin
        st_data = {2{write_data_in[15:0]}};
        st_be   = alu_result_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = write_data_in;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_shift = mem_readdata >> {addr_lo_q, 3'b000};
    ld_half  = addr_lo_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_readdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    is_read_d  = is_read_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    result_d   = result_q;
    busywait   = 1'b0;
    misaligned = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (legal) begin
            busywait  = 1'b1;
            state_d   = ACCESS;
            addr_d    = {alu_result_in[31:2], 2'b00};
            is_read_d = mem_read_in;
            funct3_d  = funct3_in;
            addr_lo_d = alu_result_in[1:0];
            wdata_d   = st_data;
            // A read wins over a simultaneous write, so it reads the full word.
            be_d      = mem_read_in ? 4'b1111 : st_be;
          end else begin
            misaligned = 1'b1;
            result_d   = 32'd0;
          end
        end
      end
      ACCESS: begin
        busywait  = 1'b1;
        mem_read  = is_read_q;
        mem_write = ~is_read_q;
        if (mem_ack) begin
          state_d = DONE;
          if (is_read_q) result_d = ld_ext;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The request inputs may be live while reset is held; keep stall/flag quiet.
    if (reset) begin
      busywait   = 1'b0;
      misaligned = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      is_read_q <= 1'b0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      is_read_q <= is_read_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      result_q  <= result_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign d_mem_result   = result_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: loads, stores, alignment faults,
// read-over-write priority and reset in the middle of an access.
module tb_data_mem_access;

  logic        clk;
  logic        reset;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in;
  logic [31:0] write_data_in;
  logic        mem_ack;
  logic [31:0] mem_readdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        busywait;
  logic [31:0] d_mem_result;
  logic        misaligned;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  data_mem_access dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .funct3_in      (funct3_in),
    .alu_result_in  (alu_result_in),
    .write_data_in  (write_data_in),
    .mem_ack        (mem_ack),
    .mem_readdata   (mem_readdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .busywait       (busywait),
    .d_mem_result   (d_mem_result),
    .misaligned     (misaligned),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one request from a negedge and plays memory: acks after ack_wait
  // strobe cycles. Returns observations; leaves inputs idle at a negedge.
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  int          ack_wait,
    output int          busy_cnt,
    output int          rd_cnt,
    output int          wr_cnt,
    output logic [31:0] addr_seen,
    output logic [31:0] wd_seen,
    output logic [3:0]  be_seen,
    output logic        held_ok,
    output logic        mis_seen,
    output logic        timed_out
  );
    int strobe_cycles;
    mem_read_in   = rd;
    mem_write_in  = wr;
    funct3_in     = f3;
    alu_result_in = addr;
    write_data_in = wdata;
    busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; strobe_cycles = 0;
    addr_seen = 32'd0; wd_seen = 32'd0; be_seen = 4'd0;
    held_ok = 1'b1; mis_seen = 1'b0; timed_out = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (misaligned) mis_seen = 1'b1;
      if (busywait) busy_cnt++;
      if (mem_read || mem_write) begin
        if (strobe_cycles == 0) begin
          addr_seen = mem_address;
          wd_seen   = mem_writedata;
          be_seen   = mem_byteenable;
        end else if (mem_address !== addr_seen || mem_writedata !== wd_seen ||
                     mem_byteenable !== be_seen) begin
          held_ok = 1'b0;
        end
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (strobe_cycles == ack_wait) begin
          mem_ack      = 1'b1;
          mem_readdata = rdata;
        end else begin
          mem_ack      = 1'b0;
          mem_readdata = 32'h5555_AAAA;
        end
        strobe_cycles++;
      end else begin
        mem_ack = 1'b0;
      end
      if (!busywait) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    mem_ack      = 1'b0;
  endtask

  int          busy, rdc, wrc;
  logic [31:0] a_s, wd_s;
  logic [3:0]  be_s;
  logic        held, mis, tmo;

  task automatic test_reset();
    reset = 1'b1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'd0;
    alu_result_in = 32'd0; write_data_in = 32'd0; mem_ack = 1'b0; mem_readdata = 32'd0;
    @(negedge clk); #1;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    checks++; if ({mem_read, mem_write, busywait, misaligned} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {mem_read, mem_write, busywait, misaligned}); end
    checks++; if ({mem_address, mem_writedata, mem_byteenable, d_mem_result} !== 100'd0) begin errors++; $display("FAIL reset_data got %h_%h_%h_%h want 0", mem_address, mem_writedata, mem_byteenable, d_mem_result); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (busywait !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL idle_noreq got busy=%b st=%0d want busy=0 st=0", busywait, dbg_state); end
    @(negedge clk);
  endtask

  task automatic test_lb();
    run_access(1, 0, 3'b000, 32'h103, 32'd0, 32'h80FF_1234, 0, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL lb_timeout got %b want 0", tmo); end
    checks++; if (d_mem_result !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_result got %h want ffffff80", d_mem_result); end
    checks++; if (busy !== 2) begin errors++; $display("FAIL lb_busy got %0d want 2", busy); end
    checks++; if (rdc !== 1 || wrc !== 0) begin errors++; $display("FAIL lb_strobes got rd=%0d wr=%0d want rd=1 wr=0", rdc, wrc); end
    checks++; if (a_s !== 32'h100 || be_s !== 4'b1111) begin errors++; $display("FAIL lb_addr got %h/%b want 00000100/1111", a_s, be_s); end
    #1;
    checks++; if (dbg_state !== 2'd0 || busywait !== 1'b0) begin errors++; $display("FAIL lb_back_idle got st=%0d busy=%b want 0/0", dbg_state, busywait); end
  endtask

  task automatic test_lhu_delayed();
    run_access(1, 0, 3'b101, 32'h102, 32'd0, 32'h9ABC_5678, 3, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (d_mem_result !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_result got %h want 00009abc", d_mem_result); end
    checks++; if (busy !== 5) begin errors++; $display("FAIL lhu_busy got %0d want 5", busy); end
    checks++; if (a_s !== 32'h100) begin errors++; $display("FAIL lhu_addr got %h want 00000100", a_s); end
    checks++; if (rdc !== 4 || held !== 1'b1) begin errors++; $display("FAIL lhu_hold got rd=%0d held=%b want 4/1", rdc, held); end
  endtask

  task automatic test_sb();
    run_access(0, 1, 3'b000, 32'h201, 32'h0000_00A5, 32'hFFFF_FFFF, 2, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (wd_s !== 32'hA5A5_A5A5 || be_s !== 4'b0010) begin errors++; $display("FAIL sb_lanes got %h/%b want a5a5a5a5/0010", wd_s, be_s); end
    checks++; if (wrc !== 3 || rdc !== 0 || held !== 1'b1) begin errors++; $display("FAIL sb_hold got wr=%0d rd=%0d held=%b want 3/0/1", wrc, rdc, held); end
    checks++; if (a_s !== 32'h200 || busy !== 4) begin errors++; $display("FAIL sb_addr_busy got %h/%0d want 00000200/4", a_s, busy); end
    checks++; if (d_mem_result !== 32'h0000_9ABC) begin errors++; $display("FAIL sb_result_kept got %h want 00009abc", d_mem_result); end
  endtask

  task automatic test_sh();
    run_access(0, 1, 3'b001, 32'h32, 32'h1234_BEEF, 32'd0, 0, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (wd_s !== 32'hBEEF_BEEF || be_s !== 4'b1100 || a_s !== 32'h30) begin errors++; $display("FAIL sh_lanes got %h/%b/%h want beefbeef/1100/00000030", wd_s, be_s, a_s); end
  endtask

  task automatic test_lh_lbu();
    run_access(1, 0, 3'b001, 32'h100, 32'd0, 32'h0000_8001, 1, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (d_mem_result !== 32'hFFFF_8001 || busy !== 3) begin errors++; $display("FAIL lh_result got %h/%0d want ffff8001/3", d_mem_result, busy); end
    run_access(1, 0, 3'b100, 32'h003, 32'd0, 32'hC300_0000, 0, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (d_mem_result !== 32'h0000_00C3) begin errors++; $display("FAIL lbu_result got %h want 000000c3", d_mem_result); end
  endtask

  task automatic test_misaligned();
    run_access(1, 0, 3'b010, 32'h102, 32'd0, 32'h1111_1111, 0, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (mis !== 1'b1 || busy !== 0 || rdc !== 0) begin errors++; $display("FAIL lw_misaligned got mis=%b busy=%0d rd=%0d want 1/0/0", mis, busy, rdc); end
    checks++; if (d_mem_result !== 32'd0) begin errors++; $display("FAIL lw_mis_result got %h want 0", d_mem_result); end
    #1;
    checks++; if (misaligned !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL mis_one_cycle got mis=%b st=%0d want 0/0", misaligned, dbg_state); end
    run_access(1, 0, 3'b100, 32'h002, 32'd0, 32'h0077_0000, 0, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (d_mem_result !== 32'h0000_0077) begin errors++; $display("FAIL lbu2_result got %h want 00000077", d_mem_result); end
    run_access(1, 0, 3'b011, 32'h000, 32'd0, 32'h1111_1111, 0, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (mis !== 1'b1 || rdc !== 0 || d_mem_result !== 32'd0) begin errors++; $display("FAIL f3_illegal got mis=%b rd=%0d res=%h want 1/0/0", mis, rdc, d_mem_result); end
  endtask

  task automatic test_read_wins();
    run_access(1, 1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h1234_5678, 0, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (rdc !== 1 || wrc !== 0 || be_s !== 4'b1111) begin errors++; $display("FAIL rw_priority got rd=%0d wr=%0d be=%b want 1/0/1111", rdc, wrc, be_s); end
    checks++; if (d_mem_result !== 32'h1234_5678) begin errors++; $display("FAIL rw_result got %h want 12345678", d_mem_result); end
  endtask

  task automatic test_reset_mid_access();
    mem_read_in = 1'b1; funct3_in = 3'b010; alu_result_in = 32'h40;
    @(negedge clk); #1;
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h40) begin errors++; $display("FAIL mid_access got rd=%b addr=%h want 1/00000040", mem_read, mem_address); end
    reset = 1'b1;
    #1;
    checks++; if ({mem_read, mem_write, busywait, misaligned} !== 4'b0000 || dbg_state !== 2'd0) begin errors++; $display("FAIL async_reset_ctrl got %b st=%0d want 0000/0", {mem_read, mem_write, busywait, misaligned}, dbg_state); end
    checks++; if (mem_address !== 32'd0 || mem_byteenable !== 4'd0 || d_mem_result !== 32'd0) begin errors++; $display("FAIL async_reset_data got %h/%b/%h want 0", mem_address, mem_byteenable, d_mem_result); end
    mem_read_in = 1'b0;
    mem_ack = 1'b1; mem_readdata = 32'h1111_1111;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (d_mem_result !== 32'd0 || dbg_state !== 2'd0 || mem_read !== 1'b0) begin errors++; $display("FAIL stale_ack got res=%h st=%0d rd=%b want 0/0/0", d_mem_result, dbg_state, mem_read); end
    mem_ack = 1'b0;
    @(negedge clk);
    run_access(1, 0, 3'b010, 32'h10, 32'd0, 32'hDEAD_BEEF, 0, busy, rdc, wrc, a_s, wd_s, be_s, held, mis, tmo);
    checks++; if (d_mem_result !== 32'hDEAD_BEEF || busy !== 2 || a_s !== 32'h10) begin errors++; $display("FAIL post_reset_lw got %h/%0d/%h want deadbeef/2/00000010", d_mem_result, busy, a_s); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_delayed();
    test_sb();
    test_sh();
    test_lh_lbu();
    test_misaligned();
    test_read_wins();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
